// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared definitions for the spi_master block.
//   - register offsets within the 8-byte window
//   - STATUS / CTRL bit positions
//   - idle MOSI level and last-toggle index
//   - transfer FSM state type
//   - bit-order helpers shared by the TX and RX shifters
package spi_master_pkg;

  localparam logic [2:0] REG_CS     = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_DIV    = 3'd4;

  localparam int STAT_BUSY = 7;
  localparam int STAT_DONE = 6;
  localparam int STAT_OVR  = 5;

  localparam int CTRL_CPOL = 0;
  localparam int CTRL_CPHA = 1;
  localparam int CTRL_LSB  = 2;

  localparam logic       MOSI_IDLE   = 1'b1;
  // A byte is 16 SCK toggles; toggle 16 is the completion edge.
  localparam logic [4:0] LAST_TOGGLE = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,   // one-clock gap so busy rises the edge after the DATA write
    ST_SHIFT
  } xfer_state_e;

  // Next bit to drive on MOSI for the selected bit order.
  function automatic logic tx_bit(input logic [7:0] v, input logic lsb);
    return lsb ? v[0] : v[7];
  endfunction

  // Drop the bit just driven.
  function automatic logic [7:0] tx_shift(input logic [7:0] v, input logic lsb);
    return lsb ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
  endfunction

  // Insert a sampled MISO bit so that after 8 samples the byte is in order.
  function automatic logic [7:0] rx_shift(input logic [7:0] v, input logic b,
                                          input logic lsb);
    return lsb ? {b, v[7:1]} : {v[6:0], b};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK timing for one byte transfer.
//   clock, reset_n : system clock, synchronous active-low reset
//   run            : high while the transfer is shifting; low clears counters
//   div            : half-period is div+1 clocks
//   toggle         : one-clock strobe, SCK changes level on this edge
//   tog_idx        : 1..16, index of the toggle happening on this edge
//   last           : strobe on toggle 16 (completion edge)
module spi_sck_gen
  import spi_master_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 toggle,
  output logic [4:0]           tog_idx,
  output logic                 last
);

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]           tog_cnt_q, tog_cnt_d;

  always_comb begin
    toggle    = run && (div_cnt_q == div);
    tog_idx   = tog_cnt_q + 5'd1;
    last      = toggle && (tog_idx == LAST_TOGGLE);
    div_cnt_d = div_cnt_q;
    tog_cnt_d = tog_cnt_q;
    if (!run) begin
      div_cnt_d = '0;
      tog_cnt_d = '0;
    end else if (toggle) begin
      // reload on every toggle so the counter never runs past div
      div_cnt_d = '0;
      tog_cnt_d = tog_idx;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      tog_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tog_cnt_q <= tog_cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: 6502-bus SPI master with programmable SCK divider,
// CPOL/CPHA, LSB-first option and busy/done/overrun status.
//   clock, reset_n      : system clock, synchronous active-low reset
//   addr, data_in, rw   : register offset, write data, 1=read
//   cs                  : active-low block select
//   data_out            : combinational read mux (0 while in reset)
//   data_out_en         : bus drive enable, ~cs & rw
//   miso, mosi, sck     : SPI bus
//   spi_cs              : software-driven chip selects
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CS_COUNT  = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [2:0]          addr,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                data_out_en,
  input  logic                rw,
  input  logic                cs,
  input  logic                miso,
  output logic                mosi,
  output logic                sck,
  output logic [CS_COUNT-1:0] spi_cs
);

  xfer_state_e          state_q, state_d;
  logic                 cs_prev_q, cs_prev_d;
  logic [CS_COUNT-1:0]  spi_cs_q, spi_cs_d;
  logic [2:0]           ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]           rx_q, rx_d;
  logic [7:0]           rx_sh_q, rx_sh_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 mosi_q, mosi_d;
  logic                 sck_q, sck_d;

  logic       toggle, last;
  logic [4:0] tog_idx;

  logic       acc_ev, wr_ev, rd_ev, busy, engaged;
  logic       cpol, cpha, lsb, odd, sample, shift_ev;
  logic [7:0] rx_next, status, rd_mux;

  spi_sck_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sck_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (state_q == ST_SHIFT),
    .div     (div_q),
    .toggle  (toggle),
    .tog_idx (tog_idx),
    .last    (last)
  );

  always_comb begin
    // one access per select: only the falling edge of cs counts
    acc_ev  = ~cs & cs_prev_q;
    wr_ev   = acc_ev & ~rw;
    rd_ev   = acc_ev & rw;
    busy    = (state_q == ST_SHIFT);
    // the START cycle already owns the shifter, so it interlocks too
    engaged = (state_q != ST_IDLE);

    cpol = ctrl_q[CTRL_CPOL];
    cpha = ctrl_q[CTRL_CPHA];
    lsb  = ctrl_q[CTRL_LSB];

    odd      = tog_idx[0];
    sample   = toggle & (cpha ? ~odd : odd);
    // CPHA=0 drives its first bit at start, so toggle 16 must not shift
    shift_ev = toggle & (cpha ? odd : (~odd & (tog_idx != LAST_TOGGLE)));
    rx_next  = sample ? rx_shift(rx_sh_q, miso, lsb) : rx_sh_q;

    state_d   = state_q;
    cs_prev_d = cs;
    spi_cs_d  = spi_cs_q;
    ctrl_d    = ctrl_q;
    div_d     = div_q;
    rx_d      = rx_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    mosi_d    = mosi_q;
    sck_d     = sck_q;

    if (wr_ev) begin
      case (addr)
        REG_CS: spi_cs_d = data_in[CS_COUNT-1:0];
        REG_DATA: begin
          if (engaged) begin
            ovr_d = 1'b1;
          end else begin
            state_d = ST_START;
            rx_sh_d = '0;
            if (cpha) begin
              tx_sh_d = data_in;
            end else begin
              mosi_d  = tx_bit(data_in, lsb);
              tx_sh_d = tx_shift(data_in, lsb);
            end
          end
        end
        REG_CTRL: if (!engaged) ctrl_d = data_in[2:0];
        REG_DIV:  if (!engaged) div_d = data_in[DIV_WIDTH-1:0];
        default: ;
      endcase
    end

    if (rd_ev) begin
      if (addr == REG_DATA)   done_d = 1'b0;
      if (addr == REG_STATUS) ovr_d  = 1'b0;
    end

    // placed after the bus decode so a completing transfer sets done
    // even if DATA is read on the same edge
    case (state_q)
      ST_IDLE:  sck_d = cpol;
      ST_START: begin
        sck_d   = cpol;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (toggle) sck_d = ~sck_q;
        rx_sh_d = rx_next;
        if (shift_ev) begin
          mosi_d  = tx_bit(tx_sh_q, lsb);
          tx_sh_d = tx_shift(tx_sh_q, lsb);
        end
        if (last) begin
          rx_d    = rx_next;
          done_d  = 1'b1;
          mosi_d  = MOSI_IDLE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status            = 8'h00;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = done_q;
    status[STAT_OVR]  = ovr_q;

    rd_mux = 8'h00;
    case (addr)
      REG_CS:     rd_mux[CS_COUNT-1:0] = spi_cs_q;
      REG_DATA:   rd_mux = rx_q;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux[2:0] = ctrl_q;
      REG_DIV:    rd_mux[DIV_WIDTH-1:0] = div_q;
      default:    rd_mux = 8'h00;
    endcase
    data_out    = reset_n ? rd_mux : 8'h00;
    data_out_en = ~cs & rw;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cs_prev_q <= 1'b1;
      spi_cs_q  <= {CS_COUNT{1'b1}};
      ctrl_q    <= '0;
      div_q     <= '0;
      rx_q      <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      mosi_q    <= MOSI_IDLE;
      sck_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_prev_q <= cs_prev_d;
      spi_cs_q  <= spi_cs_d;
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      rx_q      <= rx_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      mosi_q    <= mosi_d;
      sck_q     <= sck_d;
    end
  end

  assign spi_cs = spi_cs_q;
  assign sck    = sck_q;
  assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master.
module tb_spi_master;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_en;
  logic       rw;
  logic       cs;
  logic       miso;
  logic       mosi;
  logic       sck;
  logic [7:0] spi_cs;

  int checks   = 0;
  int failures = 0;

  spi_master #(.CS_COUNT(8), .DIV_WIDTH(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_out_en (data_out_en),
    .rw          (rw),
    .cs          (cs),
    .miso        (miso),
    .mosi        (mosi),
    .sck         (sck),
    .spi_cs      (spi_cs)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Access event lands on the posedge inside; returns #1 after it with cs high.
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clock); cs = 1'b1;
    @(negedge clock); cs = 1'b0; rw = 1'b0; addr = a; data_in = d;
    @(posedge clock); #1;
    cs = 1'b1; rw = 1'b1; addr = 3'd2;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] exp, input string tag);
    @(negedge clock); cs = 1'b1;
    @(negedge clock); cs = 1'b0; rw = 1'b1; addr = a;
    #1;
    chk(tag, {24'h0, data_out}, {24'h0, exp});
    chk({tag, "_en"}, {31'h0, data_out_en}, 32'h1);
    @(posedge clock); #1;
    cs = 1'b1; addr = 3'd2;
  endtask

  // Follows a transfer started on the previous edge. Records MOSI as seen
  // just before each rising SCK, counts busy clocks, notes the first toggle
  // and plays miso_pat MSB-first, advancing on falling SCK. With inj>0 it
  // also issues a DATA write and a STATUS read mid-transfer.
  task automatic watch(input int maxc, input logic [7:0] miso_pat, input int inj,
                       output logic [7:0] mbits, output int bcnt, output int ftog);
    logic psck, pmosi, b, seen, fin;
    int   mi;
    psck = sck; pmosi = mosi; seen = 0; fin = 0; mi = 0;
    mbits = 8'h00; bcnt = 0; ftog = 0;
    miso = miso_pat[7];
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clock); #1;
      b = (addr == 3'd2) ? data_out[7] : 1'b1;
      if (b) begin bcnt++; seen = 1; end
      if (sck !== psck && ftog == 0) ftog = c;
      if (sck === 1'b1 && psck === 1'b0) mbits = {mbits[6:0], pmosi};
      if (sck === 1'b0 && psck === 1'b1) begin
        mi++;
        miso = (mi < 8) ? miso_pat[7-mi] : 1'b1;
      end
      psck = sck; pmosi = mosi;
      if (inj > 0) begin
        if (c == inj) begin
          cs = 1'b0; rw = 1'b0; addr = 3'd1; data_in = 8'h0F;
        end else if (c == inj + 1) begin
          cs = 1'b1; rw = 1'b1; addr = 3'd2;
        end else if (c == inj + 2) begin
          cs = 1'b0; rw = 1'b1; addr = 3'd2;
          #1 chk("status_busy_ovr", {24'h0, data_out}, 32'hA0);
        end else if (c == inj + 3) begin
          cs = 1'b1;
          #1 chk("status_ovr_cleared", {24'h0, data_out}, 32'h80);
        end
      end
      if (seen && !b) begin fin = 1; break; end
    end
    chk("xfer_completes", {31'h0, fin}, 32'h1);
  endtask

  logic [7:0] mb;
  int         bc, ft, n;
  logic       ps;

  initial begin
    reset_n = 1'b0; cs = 1'b1; rw = 1'b1; addr = 3'd0; data_in = 8'h00; miso = 1'b1;

    // reset
    repeat (2) @(posedge clock);
    #1;
    chk("rst_spi_cs", {24'h0, spi_cs}, 32'hFF);
    chk("rst_sck", {31'h0, sck}, 32'h0);
    chk("rst_mosi", {31'h0, mosi}, 32'h1);
    chk("rst_data_out", {24'h0, data_out}, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    bus_read(3'd2, 8'h00, "rst_status");

    // CS register
    bus_write(3'd0, 8'hFE);
    chk("cs_pins", {24'h0, spi_cs}, 32'hFE);
    bus_read(3'd0, 8'hFE, "cs_read");

    // CTRL keeps only 3 bits; DIV readback; unused offsets read zero
    bus_write(3'd3, 8'hFF);
    bus_read(3'd3, 8'h07, "ctrl_read");
    bus_write(3'd3, 8'h00);
    bus_write(3'd4, 8'h00);
    bus_read(3'd4, 8'h00, "div_read");
    bus_write(3'd5, 8'hAA);
    bus_read(3'd5, 8'h00, "off5_read");

    // mode 0, DIV=0, MSB first
    bus_write(3'd1, 8'hDB);
    watch(200, 8'hAA, 0, mb, bc, ft);
    chk("m0_mosi", {24'h0, mb}, 32'hDB);
    chk("m0_busy", bc, 16);
    chk("m0_first_tog", ft, 2);
    bus_read(3'd2, 8'h40, "m0_status_done");
    bus_read(3'd1, 8'hAA, "m0_rx");
    bus_read(3'd2, 8'h00, "m0_done_cleared");

    // mode 3, DIV=3, LSB first
    bus_write(3'd3, 8'h07);
    bus_write(3'd4, 8'h03);
    chk("m3_sck_idle", {31'h0, sck}, 32'h1);
    bus_write(3'd1, 8'h01);
    watch(400, 8'hFF, 0, mb, bc, ft);
    chk("m3_mosi", {24'h0, mb}, 32'h80);
    chk("m3_busy", bc, 64);
    chk("m3_first_tog", ft, 5);
    chk("m3_sck_end", {31'h0, sck}, 32'h1);
    bus_read(3'd1, 8'hFF, "m3_rx");

    // DATA write while busy, mode 0, DIV=1
    bus_write(3'd3, 8'h00);
    bus_write(3'd4, 8'h01);
    bus_write(3'd1, 8'h55);
    watch(200, 8'h3C, 6, mb, bc, ft);
    chk("ovr_mosi", {24'h0, mb}, 32'h55);
    chk("ovr_busy", bc, 32);
    chk("ovr_first_tog", ft, 3);
    bus_read(3'd2, 8'h40, "ovr_status_after");
    bus_read(3'd1, 8'h3C, "ovr_rx");

    // reset after toggle 7 of a transfer
    bus_write(3'd1, 8'hA5);
    n = 0; ps = sck;
    for (int c = 0; c < 200 && n < 7; c++) begin
      @(posedge clock); #1;
      if (sck !== ps) n++;
      ps = sck;
    end
    chk("rst7_reached", n, 7);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("rst7_spi_cs", {24'h0, spi_cs}, 32'hFF);
    chk("rst7_sck", {31'h0, sck}, 32'h0);
    chk("rst7_mosi", {31'h0, mosi}, 32'h1);
    chk("rst7_data_out", {24'h0, data_out}, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    bus_read(3'd2, 8'h00, "rst7_status");
    bus_read(3'd1, 8'h00, "rst7_rx");
    bus_read(3'd4, 8'h00, "rst7_div");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
